// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 requester.
// Turns a valid/ready command into one SETUP + ACCESS transfer. The result
// comes back as a one-cycle rsp_valid pulse. A wait-state counter aborts a
// transfer whose slave holds PREADY low for too long.
module apb_cmd_master #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // The counter only has to reach TIMEOUT-1. It keeps one bit even when
  // the timeout is disabled.
  localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic            TO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0]   TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [AWIDTH-1:0]   r_paddr;
  logic [DWIDTH-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DWIDTH-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_psel_nxt;
  logic                w_penable_nxt;
  logic                w_pwrite_nxt;
  logic [AWIDTH-1:0]   w_paddr_nxt;
  logic [DWIDTH-1:0]   w_pwdata_nxt;
  logic                w_rsp_valid_nxt;
  logic [DWIDTH-1:0]   w_rsp_rdata_nxt;
  logic                w_rsp_err_nxt;
  logic                w_rsp_timeout_nxt;
  logic                w_timeout_hit;

  // cmd_ready is decoded from the registered state only.
  assign cmd_ready = (r_state == ST_IDLE);

  // The abort fires on the last allowed wait cycle. PREADY takes priority
  // over it.
  assign w_timeout_hit = TO_EN && !PREADY && (r_cnt == TO_LAST);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt   = ST_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = {CW{1'b0}};
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_pwrite ? {DWIDTH{1'b0}} : PRDATA;
          w_rsp_err_nxt     = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
        end else if (w_timeout_hit) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = {DWIDTH{1'b0}};
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and output registers. Reset clears everything at once.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CW{1'b0}};
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= {AWIDTH{1'b0}};
      r_pwdata      <= {DWIDTH{1'b0}};
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DWIDTH{1'b0}};
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master. It contains a small APB slave model, a
// directed command stream and a scoreboard monitor that checks each response.
module tb_apb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_cmd_master #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Bookkeeping
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfers = 0;
  int exp_xfers = 0;
  int last_acc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          rcyc;
    int          en;
  } exp_t;
  exp_t q[$];

  logic [31:0] cur_addr, cur_wdata;
  logic        cur_write;

  // Slave model controls
  logic [31:0] mem [0:15];
  int  wait_states = 0;
  bit  hang = 1'b0;
  int  wcnt = 0;

  assign PREADY  = PSEL && PENABLE && !hang && (wcnt >= wait_states);
  assign PSLVERR = PSEL && PENABLE && (PADDR == 32'h40);
  assign PRDATA  = (PSEL && PENABLE) ? mem[PADDR[3:0]] : 32'h0;

  // Slave state: wait-state counter, memory writes, transfer and cycle count
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (!PRESETn) wcnt <= 0;
    else if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      xfers <= xfers + 1;
      if (PWRITE && !PSLVERR) mem[PADDR[3:0]] <= PWDATA;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: APB protocol checks plus scoreboard compare on rsp_valid
  bit prev_setup = 1'b0;
  int en_cnt = 0;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PENABLE) chk("penable_without_psel", {63'd0, PSEL}, 64'd1);
      if (prev_setup) chk("setup_to_access", {62'd0, PSEL, PENABLE}, 64'd3);
      prev_setup = PSEL && !PENABLE;
      if (PSEL) begin
        chk("paddr_stable", {32'd0, PADDR}, {32'd0, cur_addr});
        chk("pwrite_stable", {63'd0, PWRITE}, {63'd0, cur_write});
        if (cur_write) chk("pwdata_stable", {32'd0, PWDATA}, {32'd0, cur_wdata});
      end
      if (PSEL && !PENABLE) en_cnt = 0;
      else if (PENABLE) en_cnt++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e.to});
          chk("rsp_cycle", 64'(cyc), 64'(e.rcyc));
          chk("penable_cycles", 64'(en_cnt), 64'(e.en));
          chk("psel_low_at_rsp", {63'd0, PSEL}, 64'd0);
        end
      end
    end else begin
      prev_setup = 1'b0;
      en_cnt = 0;
    end
  end

  // Issue one command; en = expected number of ACCESS cycles
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input bit ee, input bit et,
                      input int en, input bit push, input bit b2b, input bit keep);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 60) begin
      @(negedge PCLK); n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_wait: cmd_ready stayed low for %0d cycles, required high", n);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_spacing", 64'(cyc - last_acc), 64'd4);
    last_acc = cyc;
    cur_addr = a; cur_write = w; cur_wdata = d;
    if (push) begin
      q.push_back('{rdata: er, err: ee, to: et, rcyc: cyc + 2 + en, en: en});
      if (!et) exp_xfers++;
    end
    @(negedge PCLK);
    cmd_valid = keep;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge PCLK); n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL rsp_wait: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge PCLK);
  endtask

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cur_addr = 32'h0; cur_wdata = 32'h0; cur_write = 1'b0;
    repeat (2) @(negedge PCLK);
    // Reset state
    chk("rst_psel", {63'd0, PSEL}, 64'd0);
    chk("rst_penable", {63'd0, PENABLE}, 64'd0);
    chk("rst_pwrite", {63'd0, PWRITE}, 64'd0);
    chk("rst_paddr", {32'd0, PADDR}, 64'd0);
    chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write then read
    send(1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();
    send(1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();

    // Three wait states on a read
    send(1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();
    wait_states = 3;
    send(1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    wait_rsp();
    wait_states = 0;

    // Hung slave: timeout after 16 ACCESS cycles
    hang = 1'b1;
    send(1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b1, 16, 1'b1, 1'b0, 1'b0);
    wait_rsp();
    hang = 1'b0;

    // Slave error on write to 0x40
    send(1'b1, 32'h40, 32'h55AA55AA, 32'h0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();

    // Three back-to-back writes with cmd_valid held high
    send(1'b1, 32'h0, 32'hA0, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1);
    send(1'b1, 32'h1, 32'hA1, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
    send(1'b1, 32'h2, 32'hA2, 32'h0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    wait_rsp();
    send(1'b0, 32'h2, 32'h0, 32'hA2, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();
    send(1'b0, 32'h1, 32'h0, 32'hA1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();

    // Reset during ACCESS: silent abort
    hang = 1'b1;
    send(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", {63'd0, PSEL}, 64'd0);
    chk("midrst_penable", {63'd0, PENABLE}, 64'd0);
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    hang = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge PCLK);
    send(1'b0, 32'h0, 32'h0, 32'hA0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    wait_rsp();

    repeat (3) @(negedge PCLK);
    chk("apb_xfer_count", 64'(xfers), 64'(exp_xfers));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
